// File: rtl/codec2_fixed_pkg.sv
// Shared fixed-point constants and state encoding for the codec2 decoder blocks.
package codec2_fixed_pkg;

   localparam int unsigned N        = 32;
   localparam int unsigned Q        = 16;
   localparam int unsigned FFT_SIZE = 512;
   localparam int unsigned AW       = 10;

   // Q16 constants: 0.5, 512/(2*pi), 2*pi
   localparam logic [31:0] POINT_FIVE = 32'h0000_8000;
   localparam logic [31:0] ONE_ON_R   = 32'h0051_7CC1;
   localparam logic [31:0] TWO_PI     = 32'h0006_487F;

   // Harmonic writer state encoding (MIRROR only reachable with CONJ_MIRROR_EN)
   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_CLEAR    = 4'd1,
      S_INIT_M   = 4'd2,
      S_CHECK_M  = 4'd3,
      S_CALC_B_1 = 4'd4,
      S_CALC_B_2 = 4'd5,
      S_CALC_B_3 = 4'd6,
      S_RD_AM    = 4'd7,
      S_DELAY_1  = 4'd8,
      S_DELAY_2  = 4'd9,
      S_WRITE    = 4'd10,
      S_MIRROR   = 4'd11,
      S_INCR_M   = 4'd12,
      S_DONE     = 4'd13
   } sw_state_e;

endpackage

// File: rtl/qadd.sv
// Fixed-point adder, two's complement, wrap on overflow.
// The fraction is added separately so its carry into the integer part is explicit.
module qadd #(
   parameter int unsigned Q = 16,
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c
);

   logic [Q:0]     w_frac;
   logic [N-Q-1:0] w_int;

   assign w_frac = {1'b0, a[Q-1:0]} + {1'b0, b[Q-1:0]};
   assign w_int  = a[N-1:Q] + b[N-1:Q] + (N-Q)'(w_frac[Q]);
   assign c      = {w_int, w_frac[Q-1:0]};

endmodule

// File: rtl/sw_harmonic_writer.sv
// sw_harmonic_writer: rebuilds the 512-point synthesis spectrum Sw from the
// harmonic amplitudes in model RAM. Clears the buffer, then for m = 1..L writes
// the amplitude of harmonic m to bin round(m*Wo*512/(2*pi)).
// Optional macro CONJ_MIRROR_EN: also writes the conjugate to bin FFT_SIZE-b.
// All outputs are registered; the next-state logic also computes the output
// values for the state being entered, so each output is aligned with its state.
module sw_harmonic_writer #(
   parameter int unsigned N        = codec2_fixed_pkg::N,
   parameter int unsigned Q        = codec2_fixed_pkg::Q,
   parameter int unsigned FFT_SIZE = codec2_fixed_pkg::FFT_SIZE,
   parameter int unsigned AW       = codec2_fixed_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          startsw,
   input  logic [N-1:0]  Wo,
   input  logic [9:0]    L,
   output logic [AW-1:0] am_addr,
   input  logic [N-1:0]  am_real,
   input  logic [N-1:0]  am_imag,
   output logic [AW-1:0] sw_addr,
   output logic [N-1:0]  sw_real,
   output logic [N-1:0]  sw_imag,
   output logic          sw_we,
   output logic [N-1:0]  m1_in1,
   output logic [N-1:0]  m1_in2,
   input  logic [N-1:0]  m1_out,
   output logic          donesw
);

   import codec2_fixed_pkg::*;

   localparam logic [AW-1:0] LAST_BIN = AW'(FFT_SIZE - 1);
   localparam logic [AW-1:0] HALF_BIN = AW'(FFT_SIZE / 2);
   localparam logic [AW-1:0] FULL_BIN = AW'(FFT_SIZE);

   sw_state_e     r_state,   w_state;
   logic [N-1:0]  r_wo,      w_wo;
   logic [9:0]    r_l,       w_l;
   logic [AW-1:0] r_m,       w_m;
   logic [N-1:0]  r_prod,    w_prod;
   logic [AW-1:0] r_b,       w_b;
   logic [AW-1:0] r_am_addr, w_am_addr;
   logic [AW-1:0] r_sw_addr, w_sw_addr;
   logic [N-1:0]  r_sw_real, w_sw_real;
   logic [N-1:0]  r_sw_imag, w_sw_imag;
   logic          r_sw_we,   w_sw_we;
   logic [N-1:0]  r_m1_in1,  w_m1_in1;
   logic [N-1:0]  r_m1_in2,  w_m1_in2;
   logic          r_donesw,  w_donesw;

   logic [N-1:0]  w_rounded;
   logic          w_unused_round;
   logic          w_b_valid;
   logic          w_b_mirror;

   // Round the scaled bin position to nearest by adding one half
   qadd #(.Q(Q), .N(N)) u_round (
      .a (r_prod),
      .b (N'(POINT_FIVE)),
      .c (w_rounded)
   );

   // Only the integer bits that form the bin index are consumed
   assign w_unused_round = ^{w_rounded[N-1:Q+AW], w_rounded[Q-1:0]};

   assign w_b_valid  = (r_b != '0) && (r_b <= HALF_BIN);
   assign w_b_mirror = (r_b != '0) && (r_b <  HALF_BIN);

   // Next-state and next-output logic
   always_comb begin
      w_state   = r_state;
      w_wo      = r_wo;
      w_l       = r_l;
      w_m       = r_m;
      w_prod    = r_prod;
      w_b       = r_b;
      w_am_addr = r_am_addr;
      w_sw_addr = r_sw_addr;
      w_sw_real = r_sw_real;
      w_sw_imag = r_sw_imag;
      w_sw_we   = 1'b0;
      w_m1_in1  = r_m1_in1;
      w_m1_in2  = r_m1_in2;
      w_donesw  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (startsw) begin
               w_state   = S_CLEAR;
               w_wo      = Wo;
               w_l       = L;
               w_sw_addr = '0;
               w_sw_real = '0;
               w_sw_imag = '0;
               w_sw_we   = 1'b1;
            end
         end
         S_CLEAR: begin
            if (r_sw_addr == LAST_BIN) begin
               w_state   = S_INIT_M;
               w_sw_addr = '0;
            end else begin
               w_sw_addr = r_sw_addr + AW'(1);
               w_sw_we   = 1'b1;
            end
         end
         S_INIT_M: begin
            w_m     = AW'(1);
            w_state = S_CHECK_M;
         end
         S_CHECK_M: begin
            if (r_m <= r_l) begin
               w_state  = S_CALC_B_1;
               w_m1_in1 = N'(r_m) << Q;
               w_m1_in2 = r_wo;
            end else begin
               w_state  = S_DONE;
               w_donesw = 1'b1;
            end
         end
         S_CALC_B_1: begin
            // m*Wo is fed straight back as the second operand of the scaling
            w_state  = S_CALC_B_2;
            w_m1_in1 = N'(ONE_ON_R);
            w_m1_in2 = m1_out;
         end
         S_CALC_B_2: begin
            w_state = S_CALC_B_3;
            w_prod  = m1_out;
         end
         S_CALC_B_3: begin
            w_state   = S_RD_AM;
            w_b       = w_rounded[Q+AW-1:Q];
            w_am_addr = r_m;
         end
         S_RD_AM: begin
            w_state = S_DELAY_1;
         end
         S_DELAY_1: begin
            w_state = S_DELAY_2;
         end
         S_DELAY_2: begin
            w_state = S_WRITE;
            if (w_b_valid) begin
               w_sw_addr = r_b;
               w_sw_real = am_real;
               w_sw_imag = am_imag;
               w_sw_we   = 1'b1;
            end
         end
`ifdef CONJ_MIRROR_EN
         S_WRITE: begin
            // Conjugate copy at the negative frequency; Nyquist bin has no partner
            w_state = S_MIRROR;
            if (w_b_mirror) begin
               w_sw_addr = FULL_BIN - r_b;
               w_sw_imag = -r_sw_imag;
               w_sw_we   = 1'b1;
            end
         end
         S_MIRROR: begin
            w_state = S_INCR_M;
         end
`else
         S_WRITE: begin
            w_state = S_INCR_M;
         end
`endif
         S_INCR_M: begin
            w_m     = r_m + AW'(1);
            w_state = S_CHECK_M;
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

`ifndef CONJ_MIRROR_EN
   logic w_unused_mirror;
   assign w_unused_mirror = w_b_mirror ^ FULL_BIN[0];
`endif

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wo      <= '0;
         r_l       <= '0;
         r_m       <= '0;
         r_prod    <= '0;
         r_b       <= '0;
         r_am_addr <= '0;
         r_sw_addr <= '0;
         r_sw_real <= '0;
         r_sw_imag <= '0;
         r_sw_we   <= 1'b0;
         r_m1_in1  <= '0;
         r_m1_in2  <= '0;
         r_donesw  <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_wo      <= w_wo;
         r_l       <= w_l;
         r_m       <= w_m;
         r_prod    <= w_prod;
         r_b       <= w_b;
         r_am_addr <= w_am_addr;
         r_sw_addr <= w_sw_addr;
         r_sw_real <= w_sw_real;
         r_sw_imag <= w_sw_imag;
         r_sw_we   <= w_sw_we;
         r_m1_in1  <= w_m1_in1;
         r_m1_in2  <= w_m1_in2;
         r_donesw  <= w_donesw;
      end
   end

   assign am_addr = r_am_addr;
   assign sw_addr = r_sw_addr;
   assign sw_real = r_sw_real;
   assign sw_imag = r_sw_imag;
   assign sw_we   = r_sw_we;
   assign m1_in1  = r_m1_in1;
   assign m1_in2  = r_m1_in2;
   assign donesw  = r_donesw;

endmodule

// File: tb/tb_sw_harmonic_writer.sv
// Bench for sw_harmonic_writer: external multiplier, 2-cycle model RAM and an
// Sw RAM with a write log. Expected spectra come from a bin-rounding model.
module tb_sw_harmonic_writer;

`ifdef CONJ_MIRROR_EN
   localparam int PER = 10;
   localparam int MIR = 1;
`else
   localparam int PER = 9;
   localparam int MIR = 0;
`endif

   logic        clk;
   logic        rst;
   logic        startsw;
   logic [31:0] Wo;
   logic [9:0]  L;
   logic [9:0]  am_addr;
   logic [31:0] am_real, am_imag;
   logic [9:0]  sw_addr;
   logic [31:0] sw_real, sw_imag;
   logic        sw_we;
   logic [31:0] m1_in1, m1_in2, m1_out;
   logic        donesw;

   sw_harmonic_writer dut (
      .clk     (clk),
      .rst     (rst),
      .startsw (startsw),
      .Wo      (Wo),
      .L       (L),
      .am_addr (am_addr),
      .am_real (am_real),
      .am_imag (am_imag),
      .sw_addr (sw_addr),
      .sw_real (sw_real),
      .sw_imag (sw_imag),
      .sw_we   (sw_we),
      .m1_in1  (m1_in1),
      .m1_in2  (m1_in2),
      .m1_out  (m1_out),
      .donesw  (donesw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared multiplier: signed Q16 product, combinational
   logic signed [63:0] mul_full;
   always_comb mul_full = $signed({{32{m1_in1[31]}}, m1_in1}) * $signed({{32{m1_in2[31]}}, m1_in2});
   assign m1_out = mul_full[47:16];

   // Model RAM with two cycles of read latency
   logic [31:0] am_re_mem [0:1023];
   logic [31:0] am_im_mem [0:1023];
   logic [31:0] am_q_re, am_q_im;
   always @(posedge clk) begin
      am_q_re <= am_re_mem[am_addr];
      am_q_im <= am_im_mem[am_addr];
      am_real <= am_q_re;
      am_imag <= am_q_im;
   end

   // Sw RAM plus write log; clr_log resets the log and poisons the buffer
   logic [31:0] sw_re [0:1023];
   logic [31:0] sw_im [0:1023];
   logic [9:0]  log_addr [0:2047];
   logic        log_zero [0:2047];
   int          wr_count;
   logic        clr_log;
   always @(posedge clk) begin
      if (clr_log) begin
         for (int i = 0; i < 1024; i++) begin
            sw_re[i] <= 32'hDEAD_0000 | i;
            sw_im[i] <= 32'hBEEF_0000 | i;
         end
         wr_count <= 0;
      end else if (sw_we) begin
         sw_re[sw_addr] <= sw_real;
         sw_im[sw_addr] <= sw_imag;
         if (wr_count < 2048) begin
            log_addr[wr_count] <= sw_addr;
            log_zero[wr_count] <= (sw_real == 32'h0) && (sw_imag == 32'h0);
         end
         wr_count <= wr_count + 1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Bin index of harmonic m: round(m*Wo*512/(2*pi)) in Q16, low 10 bits kept
   function automatic int exp_bin(input logic [31:0] wo, input int m);
      longint unsigned p1, p2;
      p1 = (longint'(m) * longint'({32'h0, wo})) & 64'hFFFF_FFFF;
      p2 = (p1 * 64'h0051_7CC1) >> 16;
      return int'(((p2 + 64'h8000) >> 16) & 64'h3FF);
   endfunction

   task automatic clear_log();
      @(negedge clk); clr_log = 1'b1;
      @(negedge clk); clr_log = 1'b0;
   endtask

   // One run: pulse startsw, return the cycle donesw appears (-1 on timeout)
   task automatic do_run(input logic [31:0] wo, input int l, output int done_cyc);
      clear_log();
      Wo = wo;
      L = 10'(l);
      startsw = 1'b1;
      done_cyc = -1;
      for (int c = 1; c <= 4000; c++) begin
         @(posedge clk); #1;
         startsw = 1'b0;
         if (donesw) begin
            done_cyc = c;
            break;
         end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Compare a finished run against the reference spectrum
   task automatic check_model(input string tag, input logic [31:0] wo, input int l, input int done_cyc);
      logic [31:0] er [0:511];
      logic [31:0] ei [0:511];
      int nw, bad, b;
      for (int i = 0; i < 512; i++) begin
         er[i] = 32'h0;
         ei[i] = 32'h0;
      end
      nw = 512;
      for (int m = 1; m <= l; m++) begin
         b = exp_bin(wo, m);
         if (b >= 1 && b <= 256) begin
            er[b] = am_re_mem[m];
            ei[b] = am_im_mem[m];
            nw++;
            if (MIR == 1 && b < 256) begin
               er[512 - b] = am_re_mem[m];
               ei[512 - b] = -am_im_mem[m];
               nw++;
            end
         end
      end
      chk($sformatf("%s_done", tag), 64'(done_cyc), 64'(512 + PER * l + 3));
      chk($sformatf("%s_writes", tag), 64'(wr_count), 64'(nw));
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (log_addr[i] != 10'(i) || !log_zero[i]) bad++;
      chk($sformatf("%s_clear_seq", tag), 64'(bad), 64'd0);
      bad = 0;
      for (int i = 0; i < 512; i++)
         if (sw_re[i] !== er[i] || sw_im[i] !== ei[i]) bad++;
      chk($sformatf("%s_bins_bad", tag), 64'(bad), 64'd0);
   endtask

   typedef struct {
      logic [31:0] wo;
      int          l;
      int          bin;
      logic [31:0] re;
      logic [31:0] im;
      int          writes;
      int          done;
   } vec_t;

   initial begin
      vec_t vecs [4];
      int dc, d1, d2, n_we, n_done;
      logic [31:0] wo;
      int l;

      rst = 1'b1; startsw = 1'b0; Wo = '0; L = '0; clr_log = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         am_re_mem[i] = 32'h0;
         am_im_mem[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", 64'({sw_we, donesw, am_addr, sw_addr}), 64'd0);
      chk("reset_data", {sw_real, sw_imag}, 64'd0);
      chk("reset_mul", {m1_in1, m1_in2}, 64'd0);
      @(negedge clk); rst = 1'b0;

      // Directed vectors, am(m) = (m*1.0, -m*1.0)
      vecs[0] = '{32'h0000_2836, 0, 13,  32'h0000_0000, 32'h0000_0000, 512,               512 + 3};
      vecs[1] = '{32'h0000_2836, 3, 38,  32'h0003_0000, 32'hFFFD_0000, 512 + 3 * (1 + MIR), 512 + PER * 3 + 3};
      vecs[2] = '{32'h0003_2440, 2, 256, 32'h0001_0000, 32'hFFFF_0000, 513,               512 + PER * 2 + 3};
      vecs[3] = '{32'h0000_01E2, 2, 1,   32'h0002_0000, 32'hFFFE_0000, 512 + 2 * (1 + MIR), 512 + PER * 2 + 3};
      for (int m = 1; m < 256; m++) begin
         am_re_mem[m] = 32'(m) << 16;
         am_im_mem[m] = -(32'(m) << 16);
      end
      for (int v = 0; v < 4; v++) begin
         do_run(vecs[v].wo, vecs[v].l, dc);
         chk($sformatf("vec%0d_done", v), 64'(dc), 64'(vecs[v].done));
         chk($sformatf("vec%0d_writes", v), 64'(wr_count), 64'(vecs[v].writes));
         chk($sformatf("vec%0d_bin%0d_re", v, vecs[v].bin), 64'(sw_re[vecs[v].bin]), 64'(vecs[v].re));
         chk($sformatf("vec%0d_bin%0d_im", v, vecs[v].bin), 64'(sw_im[vecs[v].bin]), 64'(vecs[v].im));
         check_model($sformatf("vec%0d_model", v), vecs[v].wo, vecs[v].l, dc);
      end
      chk("vec1_bin13_re", 64'(sw_re[13]), 64'h0);

      // Conjugate mirror sequence: bin 13 always written, bin 499 only with mirroring
      am_re_mem[1] = 32'h0001_0000;
      am_im_mem[1] = 32'h0000_8000;
      do_run(32'h0000_2836, 1, dc);
      chk("mirror_done", 64'(dc), 64'(512 + PER + 3));
      chk("mirror_bin13_re", 64'(sw_re[13]), 64'h0001_0000);
      chk("mirror_bin13_im", 64'(sw_im[13]), 64'h0000_8000);
      chk("mirror_bin499_re", 64'(sw_re[499]), (MIR == 1) ? 64'h0001_0000 : 64'h0);
      chk("mirror_bin499_im", 64'(sw_im[499]), (MIR == 1) ? 64'hFFFF_8000 : 64'h0);
      chk("mirror_writes", 64'(wr_count), 64'(513 + MIR));

      // startsw held high through DONE: second run begins on the next IDLE cycle
      clear_log();
      Wo = 32'h0000_2836; L = 10'd0; startsw = 1'b1;
      d1 = -1; d2 = -1;
      for (int c = 1; c <= 1200; c++) begin
         @(posedge clk); #1;
         if (donesw) begin
            if (d1 < 0) d1 = c;
            else begin
               d2 = c;
               startsw = 1'b0;
               break;
            end
         end
      end
      startsw = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("held_first_done", 64'(d1), 64'd515);
      chk("held_second_done", 64'(d2), 64'd1031);
      chk("held_writes", 64'(wr_count), 64'd1024);

      // Reset in the middle of CLEAR abandons the run
      clear_log();
      Wo = 32'h0000_2836; L = 10'd5; startsw = 1'b1;
      @(posedge clk); #1; startsw = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ctrl", 64'({sw_we, donesw, am_addr, sw_addr}), 64'd0);
      chk("midrst_data", {sw_real, sw_imag}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      n_we = 0; n_done = 0;
      for (int c = 0; c < 700; c++) begin
         @(posedge clk); #1;
         if (sw_we) n_we++;
         if (donesw) n_done++;
      end
      chk("midrst_idle_we", 64'(n_we), 64'd0);
      chk("midrst_idle_done", 64'(n_done), 64'd0);

      // Randomized runs against the reference model
      for (int r = 0; r < 6; r++) begin
         wo = $urandom_range(32'h0003_2440, 1);
         l = $urandom_range(30, 0);
         for (int m = 1; m < 256; m++) begin
            am_re_mem[m] = $urandom;
            am_im_mem[m] = $urandom;
         end
         do_run(wo, l, dc);
         check_model($sformatf("rand%0d_wo%0h_l%0d", r, wo, l), wo, l, dc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
